// File: rtl/nrf_spi_sequencer.sv
// ---------------------------------------------------------------------------
// nrf_spi_sequencer
//   SPI master frame sequencer for an nRF24L01 radio. It accepts one command
//   (command byte plus a 0..32 byte payload count) and runs one CSN-low frame.
//   The frame shifts out the command byte and then the payload, MSB first, in
//   SPI mode 0. It returns the STATUS byte and every payload byte received on
//   MISO. After the frame it holds CSN high for a minimum idle gap.
//
// Parameters
//   SCK_HALF  clk_50 cycles per SCK half-period (1..255)
//   CSN_IDLE  minimum clk_50 cycles CSN stays high between frames (1..255)
//
// Ports
//   clk_50, rst_n            system clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake; cmd_byte, cmd_len latched on it
//   tx_req / tx_data         payload byte request pulse; tx_data sampled with it
//   rx_data                  last captured byte, held until the next capture
//   status_valid / rx_valid  pulse when rx_data holds STATUS / a payload byte
//   busy, done               frame in progress; pulse when CSN returns high
//   spi_csn/sck/mosi/miso    SPI pins (MISO sampled directly, no synchroniser)
// ---------------------------------------------------------------------------
module nrf_spi_sequencer #(
    parameter int unsigned SCK_HALF = 5,
    parameter int unsigned CSN_IDLE = 4
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [5:0] cmd_len,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       status_valid,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       spi_csn,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, GAP} state_t;

    localparam logic [7:0] HALF_LAST   = 8'(SCK_HALF - 1);
    // Half-count value one cycle before a half ends; unreachable when SCK_HALF==1.
    localparam logic [7:0] HALF_PRE    = 8'(SCK_HALF - 2);
    localparam logic [7:0] GAP_LAST    = 8'(CSN_IDLE - 1);
    localparam bit         HALF_IS_ONE = (SCK_HALF == 1);

    state_t     r_state;
    logic [7:0] r_half_cnt;
    logic [7:0] r_gap_cnt;
    logic [2:0] r_bit_cnt;
    logic [5:0] r_byte_cnt;
    logic [5:0] r_len;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;

    logic       r_cmd_ready;
    logic       r_busy;
    logic       r_csn;
    logic       r_sck;
    logic       r_mosi;
    logic [7:0] r_rx_data;
    logic       r_tx_req;
    logic       r_status_valid;
    logic       r_rx_valid;
    logic       r_done;

    logic       w_half_end;
    logic       w_last_bit;
    logic       w_more_bytes;

    assign w_half_end   = (r_half_cnt == HALF_LAST);
    assign w_last_bit   = (r_bit_cnt == 3'd7);
    assign w_more_bytes = (r_byte_cnt != r_len);

    // NOTE: state registers use non-blocking assignments so every branch below
    // reads the values from before this clock edge.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            // GAP with the counter at its last value gives IDLE on the first
            // edge after reset while cmd_ready and busy both stay low in reset.
            r_state        <= GAP;
            r_gap_cnt      <= GAP_LAST;
            r_half_cnt     <= 8'd0;
            r_bit_cnt      <= 3'd0;
            r_byte_cnt     <= 6'd0;
            r_len          <= 6'd0;
            r_tx_sr        <= 8'd0;
            r_rx_sr        <= 8'd0;
            r_cmd_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_csn          <= 1'b1;
            r_sck          <= 1'b0;
            r_mosi         <= 1'b0;
            r_rx_data      <= 8'd0;
            r_tx_req       <= 1'b0;
            r_status_valid <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_tx_req       <= 1'b0;
            r_status_valid <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_done         <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= SHIFT;
                        r_len       <= (cmd_len > 6'd32) ? 6'd32 : cmd_len;
                        r_tx_sr     <= cmd_byte;
                        r_mosi      <= cmd_byte[7];
                        r_csn       <= 1'b0;
                        r_sck       <= 1'b0;
                        r_half_cnt  <= 8'd0;
                        r_bit_cnt   <= 3'd0;
                        r_byte_cnt  <= 6'd0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (!w_half_end) begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                        // Raise tx_req so it is high in the last cycle of the byte.
                        if (r_sck && w_last_bit && w_more_bytes && (r_half_cnt == HALF_PRE))
                            r_tx_req <= 1'b1;
                    end else begin
                        r_half_cnt <= 8'd0;
                        if (!r_sck) begin
                            // Rising SCK: the slave's bit has been stable for a full low half.
                            r_sck   <= 1'b1;
                            r_rx_sr <= {r_rx_sr[6:0], spi_miso};
                            if (HALF_IS_ONE && w_last_bit && w_more_bytes)
                                r_tx_req <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (!w_last_bit) begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_mosi    <= r_tx_sr[6];
                                r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
                            end else begin
                                r_bit_cnt <= 3'd0;
                                r_rx_data <= r_rx_sr;
                                if (r_byte_cnt == 6'd0)
                                    r_status_valid <= 1'b1;
                                else
                                    r_rx_valid <= 1'b1;
                                if (w_more_bytes) begin
                                    // Next byte starts immediately: no gap between bytes.
                                    r_byte_cnt <= r_byte_cnt + 6'd1;
                                    r_tx_sr    <= tx_data;
                                    r_mosi     <= tx_data[7];
                                end else begin
                                    r_state <= CS_HOLD;
                                    r_mosi  <= 1'b0;
                                end
                            end
                        end
                    end
                end

                CS_HOLD: begin
                    if (w_half_end) begin
                        r_state    <= GAP;
                        r_csn      <= 1'b1;
                        r_done     <= 1'b1;
                        r_gap_cnt  <= 8'd0;
                        r_half_cnt <= 8'd0;
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign spi_csn      = r_csn;
    assign spi_sck      = r_sck;
    assign spi_mosi     = r_mosi;
    assign rx_data      = r_rx_data;
    assign tx_req       = r_tx_req;
    assign status_valid = r_status_valid;
    assign rx_valid     = r_rx_valid;
    assign done         = r_done;

endmodule

// File: tb/tb_nrf_spi_sequencer.sv
`timescale 1ns/1ps
module tb_nrf_spi_sequencer;

    localparam int H        = 5;
    localparam int IDLE_CYC = 4;

    logic       clk_50    = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte  = 8'd0;
    logic [5:0] cmd_len   = 6'd0;
    logic [7:0] tx_data   = 8'd0;
    logic       spi_miso  = 1'b0;
    logic       cmd_ready, tx_req, status_valid, rx_valid, busy, done;
    logic       spi_csn, spi_sck, spi_mosi;
    logic [7:0] rx_data;

    nrf_spi_sequencer #(.SCK_HALF(H), .CSN_IDLE(IDLE_CYC)) dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_len(cmd_len),
        .tx_req(tx_req), .tx_data(tx_data),
        .rx_data(rx_data), .status_valid(status_valid), .rx_valid(rx_valid),
        .busy(busy), .done(done),
        .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct packed {
        logic       is_status;
        logic [7:0] val;
    } rx_exp_t;

    // Scoreboard queues filled by the stimulus, drained by the monitors.
    logic [7:0] exp_mosi[$];
    rx_exp_t    exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] slave_q[$];
    int         slave_len[$];
    int         exp_csn[$];

    int total = 0;
    int bad   = 0;
    int accept_cnt  = 0;
    int done_cnt    = 0;
    int exp_accepts = 0;

    logic [7:0] g_tx[0:32];
    logic [7:0] g_rx[0:32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the command byte followed by min(len,32)
    // payload bytes; the slave answers with one byte per frame byte.
    function automatic void push_expect(input logic [7:0] cmd, input int len_in);
        int n;
        n = (len_in > 32) ? 32 : len_in;
        exp_mosi.push_back(cmd);
        exp_rx.push_back({1'b1, g_rx[0]});
        slave_q.push_back(g_rx[0]);
        slave_len.push_back(n + 1);
        for (int k = 1; k <= n; k++) begin
            exp_mosi.push_back(g_tx[k]);
            tx_src.push_back(g_tx[k]);
            exp_rx.push_back({1'b0, g_rx[k]});
            slave_q.push_back(g_rx[k]);
        end
        exp_csn.push_back(H * (16 * (n + 1) + 1));
        exp_accepts++;
    endfunction

    function automatic void fill_random();
        for (int i = 0; i <= 32; i++) begin
            g_tx[i] = 8'($urandom);
            g_rx[i] = 8'($urandom);
        end
    endfunction

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk_50);
        while (done !== 1'b1 && k < 6000) begin
            @(negedge clk_50);
            k++;
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        @(posedge clk_50); #1;
        while (cmd_ready !== 1'b1 && k < 200) begin
            @(posedge clk_50); #1;
            k++;
        end
        check({name, "_ready"}, cmd_ready, 1);
    endtask

    task automatic end_of_frame(input string name);
        check({name, "_mosi_left"}, exp_mosi.size(), 0);
        check({name, "_rx_left"},   exp_rx.size(), 0);
        check({name, "_tx_left"},   tx_src.size(), 0);
        check({name, "_accepts"},   accept_cnt, exp_accepts);
        check({name, "_busy"},      busy, 0);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int len_in, input string name);
        push_expect(cmd, len_in);
        @(posedge clk_50); #1;
        cmd_byte  = cmd;
        cmd_len   = 6'(len_in);
        cmd_valid = 1'b1;
        @(posedge clk_50); #1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'($urandom);
        cmd_len   = 6'($urandom);
        wait_done(name);
        wait_ready(name);
        end_of_frame(name);
    endtask

    task automatic clear_model();
        exp_mosi.delete();
        exp_rx.delete();
        tx_src.delete();
        slave_q.delete();
        slave_len.delete();
        exp_csn.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_csn"},   spi_csn, 1);
        check({name, "_sck"},   spi_sck, 0);
        check({name, "_mosi"},  spi_mosi, 0);
        check({name, "_rx"},    rx_data, 0);
        check({name, "_pulse"}, {tx_req, status_valid, rx_valid, done}, 0);
        check({name, "_busy"},  busy, 0);
        check({name, "_ready"}, cmd_ready, 0);
    endtask

    // Slave model: presents bit 7 when CSN falls and the next bit on each SCK fall.
    logic [7:0] s_cur;
    int         s_bit, s_left;
    logic       s_prev_csn = 1'b1, s_prev_sck = 1'b0, s_active = 1'b0;
    initial begin : slave
        forever begin
            @(negedge clk_50);
            if (!rst_n || spi_csn) begin
                spi_miso   = 1'b0;
                s_prev_csn = 1'b1;
                s_prev_sck = 1'b0;
                s_active   = 1'b0;
            end else begin
                if (s_prev_csn) begin
                    s_left   = (slave_len.size() > 0) ? slave_len.pop_front() : 1;
                    s_cur    = (slave_q.size() > 0) ? slave_q.pop_front() : 8'd0;
                    s_left   = s_left - 1;
                    s_bit    = 7;
                    s_active = 1'b1;
                    spi_miso = s_cur[7];
                end else if (s_prev_sck && !spi_sck && s_active) begin
                    if (s_bit == 0) begin
                        if (s_left > 0) begin
                            s_cur    = (slave_q.size() > 0) ? slave_q.pop_front() : 8'd0;
                            s_left   = s_left - 1;
                            s_bit    = 7;
                            spi_miso = s_cur[7];
                        end else begin
                            s_active = 1'b0;
                            spi_miso = 1'b0;
                        end
                    end else begin
                        s_bit    = s_bit - 1;
                        spi_miso = s_cur[s_bit];
                    end
                end
                s_prev_csn = 1'b0;
                s_prev_sck = spi_sck;
            end
        end
    end

    // Payload source: hands over the next queued byte when tx_req is seen.
    initial begin : tx_source
        forever begin
            @(negedge clk_50);
            if (rst_n && tx_req) begin
                check("tx_req_expected", tx_src.size() > 0, 1);
                if (tx_src.size() > 0) tx_data = tx_src.pop_front();
            end
        end
    end

    // Monitor: frame timing, mode-0 rules, MOSI bytes and captured bytes.
    logic       m_prev_csn = 1'b1, m_prev_sck = 1'b0, m_prev_mosi = 1'b0;
    logic       m_gap_on = 1'b0, m_rise_seen = 1'b0;
    int         m_low_cnt = 0, m_gap_cnt = 0, m_stable = 0, m_since_rise = 0, m_bits = 0;
    logic [7:0] m_byte = 8'd0;
    rx_exp_t    m_e;
    initial begin : monitor
        forever begin
            @(negedge clk_50);
            if (!rst_n) begin
                m_prev_csn = 1'b1; m_prev_sck = 1'b0; m_prev_mosi = 1'b0;
                m_gap_on = 1'b0; m_rise_seen = 1'b0; m_low_cnt = 0; m_bits = 0;
                m_stable = 0; m_since_rise = 0;
            end else begin
                m_stable = (spi_mosi == m_prev_mosi) ? m_stable + 1 : 0;
                if (cmd_valid && cmd_ready) accept_cnt++;
                if (done) done_cnt++;
                if (m_gap_on) begin
                    if (cmd_ready) begin
                        check("gap_cycles", m_gap_cnt, IDLE_CYC);
                        m_gap_on = 1'b0;
                    end else begin
                        m_gap_cnt++;
                    end
                end
                if (spi_csn) begin
                    check("idle_sck_low", spi_sck, 0);
                    check("idle_mosi_low", spi_mosi, 0);
                    if (!m_prev_csn) begin
                        check("done_at_csn_rise", done, 1);
                        check("busy_in_gap", busy, 1);
                        check("csn_frame_expected", exp_csn.size() > 0, 1);
                        if (exp_csn.size() > 0) check("csn_low_cycles", m_low_cnt, exp_csn.pop_front());
                        m_gap_on  = 1'b1;
                        m_gap_cnt = 1;
                    end else if (done) begin
                        check("done_spurious", done, 0);
                    end
                end else begin
                    if (done) check("done_while_csn_low", done, 0);
                    if (m_prev_csn) begin
                        m_bits = 0; m_rise_seen = 1'b0; m_low_cnt = 0;
                    end
                    m_low_cnt++;
                    m_since_rise++;
                    if (!m_prev_sck && spi_sck) begin
                        check("mosi_setup", m_stable >= H, 1);
                        if (m_rise_seen) check("sck_period", m_since_rise, 2 * H);
                        m_rise_seen  = 1'b1;
                        m_since_rise = 0;
                        m_byte = {m_byte[6:0], spi_mosi};
                        m_bits++;
                        if (m_bits == 8) begin
                            m_bits = 0;
                            check("mosi_byte_expected", exp_mosi.size() > 0, 1);
                            if (exp_mosi.size() > 0) check("mosi_byte", m_byte, exp_mosi.pop_front());
                        end
                    end
                end
                if (status_valid || rx_valid) begin
                    check("single_capture_pulse", status_valid & rx_valid, 0);
                    check("rx_expected", exp_rx.size() > 0, 1);
                    if (exp_rx.size() > 0) begin
                        m_e = exp_rx.pop_front();
                        check("rx_kind_status", status_valid, m_e.is_status);
                        check("rx_data", rx_data, m_e.val);
                    end
                end
                m_prev_csn  = spi_csn;
                m_prev_sck  = spi_sck;
                m_prev_mosi = spi_mosi;
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        int k;
        int d0;
        int len_r;

        repeat (2) @(posedge clk_50);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk_50); #1;
        check("ready_after_reset", cmd_ready, 1);
        check("busy_after_reset", busy, 0);

        // Command 0xFF, no payload, STATUS 0x0E.
        fill_random();
        g_rx[0] = 8'h0E;
        send_frame(8'hFF, 0, "nop");

        // Single payload byte 0xA5.
        fill_random();
        g_tx[1] = 8'hA5;
        send_frame(8'h20, 1, "wr1");

        // 32-byte payload, slave returns 0x00..0x1F.
        fill_random();
        for (int i = 1; i <= 32; i++) g_rx[i] = 8'(i - 1);
        send_frame(8'h61, 32, "rd32");

        // cmd_len=40 clamps to 32; cmd_valid held high through the whole frame.
        fill_random();
        push_expect(8'h3C, 40);
        @(posedge clk_50); #1;
        cmd_byte  = 8'h3C;
        cmd_len   = 6'd40;
        cmd_valid = 1'b1;
        @(posedge clk_50); #1;
        fill_random();
        push_expect(8'hC3, 2);
        cmd_byte = 8'hC3;
        cmd_len  = 6'd2;
        wait_done("hold_a");
        check("hold_single_accept", accept_cnt, exp_accepts - 1);
        k = 0;
        @(posedge clk_50); #1;
        while (cmd_ready !== 1'b1 && k < 200) begin
            @(posedge clk_50); #1;
            k++;
        end
        check("hold_ready_after_gap", cmd_ready, 1);
        @(posedge clk_50); #1;
        cmd_valid = 1'b0;
        wait_done("hold_b");
        wait_ready("hold_b");
        end_of_frame("hold_b");

        // Reset in the middle of byte 2 of a 4-byte payload frame.
        fill_random();
        push_expect(8'hA0, 4);
        @(posedge clk_50); #1;
        cmd_byte  = 8'hA0;
        cmd_len   = 6'd4;
        cmd_valid = 1'b1;
        @(posedge clk_50); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (exp_rx.size() > 3 && k < 2000) begin
            @(negedge clk_50);
            k++;
        end
        check("abort_reach_byte2", exp_rx.size(), 3);
        repeat (20) @(posedge clk_50);
        #1;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        clear_model();
        repeat (3) @(posedge clk_50);
        #1;
        check("abort_no_done", done_cnt, d0);
        rst_n = 1'b1;
        @(posedge clk_50); #1;
        check("ready_after_abort", cmd_ready, 1);
        fill_random();
        send_frame(8'h07, 3, "after_abort");

        // Randomised frames, lengths including clamped values.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            len_r = int'($urandom_range(0, 40));
            send_frame(8'($urandom), len_r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrf_spi_sequencer.md
NRF_SPI_SEQUENCER -- requirements
Module: nrf_spi_sequencer

Interface
REQ-001 Parameter SCK_HALF, default 5: clk_50 cycles per SCK half-period (5 MHz SCK); legal range 1..255.
REQ-002 Parameter CSN_IDLE, default 4: minimum clk_50 cycles CSN stays high between frames; legal range 1..255.
REQ-003 clk_50  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-007 cmd_byte  in  8  nRF24L01 command byte, shifted first.
REQ-008 cmd_len  in  6  payload byte count following the command, 0..32.
REQ-009 tx_req  out  1  one-cycle pulse; tx_data is sampled in the same cycle.
REQ-010 tx_data  in  8  next payload byte to transmit.
REQ-011 rx_data  out  8  last received byte; held until the next capture.
REQ-012 status_valid  out  1  one-cycle pulse; rx_data holds the STATUS byte shifted in during cmd_byte.
REQ-013 rx_valid  out  1  one-cycle pulse; rx_data holds a payload byte.
REQ-014 busy  out  1  high from command acceptance until cmd_ready returns.
REQ-015 done  out  1  one-cycle pulse in the cycle CSN returns high.
REQ-016 spi_csn  out  1  chip select, active low.
REQ-017 spi_sck  out  1  SPI clock, mode 0, idle low.
REQ-018 spi_mosi  out  1  serial data out, MSB first.
REQ-019 spi_miso  in  1  serial data in; sampled directly, no synchroniser.

Function
REQ-020 The block SHALL use the states IDLE, SHIFT, CS_HOLD and GAP.
REQ-021 cmd_ready SHALL equal (state==IDLE); a command is accepted on cmd_valid&cmd_ready; in other states cmd_valid is ignored.
REQ-022 On acceptance the block SHALL latch cmd_byte and len=min(cmd_len,32), and enter SHIFT.
REQ-023 In the cycle after acceptance spi_csn SHALL go low and spi_mosi SHALL equal cmd_byte[7].
REQ-024 Bit timing in SHIFT SHALL be: SCK low for SCK_HALF cycles, then high for SCK_HALF cycles.
REQ-025 spi_mosi SHALL change only at the start of a low half; spi_miso SHALL be sampled on the clk_50 edge where spi_sck rises.
REQ-026 Each byte SHALL last 16*SCK_HALF cycles; bytes are back-to-back, with no gap; frame length is len+1 bytes.
REQ-027 For payload byte k (1..len), tx_req SHALL pulse in the last cycle of byte k-1; tx_data[7] SHALL drive spi_mosi in the next cycle.
REQ-028 When len=0, tx_req SHALL never pulse.
REQ-029 In the cycle after each byte's final high half, the assembled byte SHALL appear on rx_data.
REQ-030 That same cycle SHALL pulse status_valid for byte 0, and rx_valid for bytes 1..len.
REQ-031 After the last byte, CS_HOLD SHALL hold SCK low and CSN low for SCK_HALF cycles.
REQ-032 spi_csn SHALL then go high and done SHALL pulse.
REQ-033 spi_csn SHALL be low for exactly SCK_HALF*(16*(len+1)+1) cycles per frame.
REQ-034 GAP SHALL hold CSN high for CSN_IDLE cycles, then return to IDLE with cmd_ready high.
REQ-035 spi_mosi SHALL be 0 whenever spi_csn is high.
REQ-036 busy SHALL equal !cmd_ready.
REQ-037 Half-period and bit counters SHALL be sized for SCK_HALF<=255 and 33 bytes, and SHALL wrap only by explicit reload.

Reset
REQ-038 While rst_n=0, regardless of state, outputs SHALL be: spi_csn=1, spi_sck=0, spi_mosi=0, rx_data=0; all pulses 0; busy=0; cmd_ready=0.
REQ-039 The block SHALL enter IDLE on the first clk_50 edge after rst_n rises; cmd_ready=1 from then on.
REQ-040 A reset mid-frame SHALL abort the frame without a done pulse; the next command after reset SHALL start a fresh frame.

Verification
REQ-041 The bench SHALL cover the following scenarios:
- cmd 0xFF, len 0, MISO replays 0x0E -> CSN low 85 cycles; status_valid with rx_data=0x0E; done; cmd_ready back 4 cycles after CSN high.
- cmd 0x20, len 1, tx_data 0xA5 -> MOSI bitstream 0x20,0xA5; one tx_req; one rx_valid; CSN low 165 cycles.
- cmd 0x61, len 32, MISO model returns 0x00..0x1F -> 32 rx_valid with matching bytes; 32 tx_req; no inter-byte SCK gap.
- cmd_len=40 -> frame is 33 bytes; cmd_valid held during busy -> no second acceptance until GAP ends.
- rst_n low during byte 2 of a len-4 frame -> CSN=1 and SCK=0 immediately; no done; next command completes normally.
- Mode-0 checker on every frame: MOSI stable for SCK_HALF cycles before each SCK rise; SCK idle low whenever CSN is high.
